// File: rtl/i2s_define.sv
// Shared definitions for the i2s subsystem.
//   I2S_DATA_WIDTH : default word width (overridable through the macro)
//   I2S_LEN_*      : channel length codes carried on len_i
//   rx_state_e     : receiver state encoding
//   len_to_bits()  : length code -> number of bits per channel word
`ifndef I2S_DATA_WIDTH
`define I2S_DATA_WIDTH 32
`endif

package i2s_define;

  localparam int I2S_DATA_WIDTH = `I2S_DATA_WIDTH;

  // Bit counter width; must hold the largest channel length (32).
  localparam int I2S_CNT_W = 6;

  localparam logic [1:0] I2S_LEN_8  = 2'd0;
  localparam logic [1:0] I2S_LEN_16 = 2'd1;
  localparam logic [1:0] I2S_LEN_24 = 2'd2;
  localparam logic [1:0] I2S_LEN_32 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_e;

  function automatic logic [I2S_CNT_W-1:0] len_to_bits(input logic [1:0] code);
    logic [I2S_CNT_W-1:0] bits;
    case (code)
      I2S_LEN_8:  bits = 6'd8;
      I2S_LEN_16: bits = 6'd16;
      I2S_LEN_24: bits = 6'd24;
      default:    bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Valid/ready word stream from the I2S receiver to the register/FIFO layer.
//   data  : received word, right-justified, zero-extended
//   chn   : channel of data (0=left, 1=right)
//   valid : data/chn valid
//   ready : consumer accepts when valid && ready
// master = producer (receiver), slave = consumer.
interface i2s_rx_if import i2s_define::*; #(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  chn;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output chn,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  chn,
    input  valid,
    output ready
  );

endinterface

// File: rtl/i2s_edge_sync.sv
// Brings the asynchronous I2S lines into the clk_i domain and detects
// bit-clock edges.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   sck_i/ws_i/sd_i : raw external lines
//   sck_rise / sck_fall : one-cycle strobes on synchronized sck edges
//   ws_s / sd_s  : ws and sd from the same synchronizer depth as sck, so they
//                  line up with the edge strobes
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise,
  output logic sck_fall,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_p;
  logic [SYNC_STAGES-1:0] ws_p;
  logic [SYNC_STAGES-1:0] sd_p;
  logic                   sck_prev;

  // Synchronizer chains: new sample enters at bit 0, oldest sits at the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_p    <= '0;
      ws_p     <= '0;
      sd_p     <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_p    <= SYNC_STAGES'({sck_p, sck_i});
      ws_p     <= SYNC_STAGES'({ws_p, ws_i});
      sd_p     <= SYNC_STAGES'({sd_p, sd_i});
      sck_prev <= sck_p[SYNC_STAGES-1];
    end
  end

  // Edge strobes
  assign sck_rise = sck_p[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall = ~sck_p[SYNC_STAGES-1] & sck_prev;
  assign ws_s     = ws_p[SYNC_STAGES-1];
  assign sd_s     = sd_p[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver. Oversamples an externally driven SCK/WS/SD,
// deserializes one channel word per WS half-period (MSB first) and offers it
// on a valid/ready stream.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   en_i         : receiver enable; low forces IDLE without err/ovf
//   len_i        : channel length code (0=8, 1=16, 2=24, 3=32 bits)
//   sck_i/ws_i/sd_i : external I2S lines (asynchronous)
//   rx           : output word stream (data/chn/valid, ready)
//   ovf_o        : pulse, completed word dropped because output was full
//   err_o        : pulse, WS toggled before the word was complete
//   busy_o       : receiver state is not IDLE
// Words longer than the slot are never collected; extra slot bits after the
// last data bit are ignored in DONE until the next WS change.
module i2s_rx import i2s_define::*; #(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] len_i,
  input  logic       sck_i,
  input  logic       ws_i,
  input  logic       sd_i,
  i2s_rx_if.master   rx,
  output logic       ovf_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam logic [I2S_CNT_W-1:0] CNT_ONE = 1;

  logic sck_rise;
  logic sck_fall_unused;
  logic ws_s;
  logic sd_s;

  i2s_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sck_i    (sck_i),
    .ws_i     (ws_i),
    .sd_i     (sd_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall_unused),
    .ws_s     (ws_s),
    .sd_s     (sd_s)
  );

  rx_state_e              state_q, state_d;
  logic [I2S_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [I2S_CNT_W-1:0]   len_q, len_d;
  logic [DATA_WIDTH-2:0]  sh_q, sh_d;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   chn_q, chn_d;
  logic                   ws_q, ws_q_d;
  logic                   word_done;
  logic                   err_set;

  // Deserializer state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sh_q    <= '0;
      chn_q   <= 1'b0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      chn_q   <= chn_d;
      ws_q    <= ws_q_d;
    end
  end

  // Bit-event processing: shift first, then react to a WS change, so a word
  // whose LSB arrives on the same edge as the WS toggle still completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sh_d      = sh_q;
    chn_d     = chn_q;
    ws_q_d    = ws_q;
    word_done = 1'b0;
    err_set   = 1'b0;
    cnt_inc   = cnt_q + CNT_ONE;
    shifted   = {sh_q, sd_s};

    // ws_q follows the line even while disabled so re-enabling does not
    // mistake an old toggle for a fresh word boundary.
    if (sck_rise) begin
      ws_q_d = ws_s;
    end

    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end else if (sck_rise) begin
      if (state_q == SHIFT) begin
        sh_d  = shifted[DATA_WIDTH-2:0];
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          word_done = 1'b1;
          state_d   = DONE;
        end
      end
      if (ws_s != ws_q) begin
        if ((state_q == SHIFT) && !word_done) begin
          err_set = 1'b1;
        end
        state_d = SHIFT;
        cnt_d   = '0;
        sh_d    = '0;
        chn_d   = ws_s;
        len_d   = len_to_bits(len_i);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx.data  <= '0;
      rx.chn   <= 1'b0;
      rx.valid <= 1'b0;
      ovf_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      ovf_o <= 1'b0;
      err_o <= err_set;
      if (word_done) begin
        // A word landing on the acceptance cycle replaces the old one.
        if (rx.valid && !rx.ready) begin
          ovf_o <= 1'b1;
        end else begin
          rx.data  <= shifted;
          rx.chn   <= chn_q;
          rx.valid <= 1'b1;
        end
      end else if (rx.valid && rx.ready) begin
        rx.valid <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] len;
  logic       sck;
  logic       ws;
  logic       sd;
  logic       ovf;
  logic       err;
  logic       busy;

  i2s_rx_if #(.DATA_WIDTH(DW)) rx_bus ();

  i2s_rx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .len_i  (len),
    .sck_i  (sck),
    .ws_i   (ws),
    .sd_i   (sd),
    .rx     (rx_bus),
    .ovf_o  (ovf),
    .err_o  (err),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log accepted words and count pulses.
  logic [31:0] acc_data [0:63];
  logic        acc_chn  [0:63];
  int          acc_cyc  [0:63];
  int          acc_n = 0;
  int          ovf_n = 0;
  int          err_n = 0;

  always @(negedge clk) begin
    if (rx_bus.valid && rx_bus.ready && acc_n < 64) begin
      acc_data[acc_n] = rx_bus.data;
      acc_chn[acc_n]  = rx_bus.chn;
      acc_cyc[acc_n]  = cyc;
      acc_n++;
    end
    if (ovf) ovf_n++;
    if (err) err_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial stream built as one entry per SCK period.
  logic ws_arr   [0:255];
  logic sd_arr   [0:255];
  int   rise_arr [0:255];
  int   n_ent;

  task automatic stream_clear();
    n_ent = 0;
    for (int i = 0; i < 256; i++) begin
      ws_arr[i]   = 1'b0;
      sd_arr[i]   = 1'b0;
      rise_arr[i] = 0;
    end
  endtask

  // One WS half: the first edge carries the WS change (and the previous
  // word's LSB), data bits follow MSB first; the LSB may land on the next
  // half's first edge, which is why entry 0 is left untouched here.
  task automatic add_half(input logic w, input int slots, input logic [31:0] word,
                          input int nbits, input logic fill);
    for (int i = 0; i < slots; i++) ws_arr[n_ent + i] = w;
    for (int i = 1; i < slots; i++) sd_arr[n_ent + i] = fill;
    for (int b = 0; b < nbits; b++) sd_arr[n_ent + 1 + b] = word[nbits - 1 - b];
    n_ent += slots;
  endtask

  task automatic add_edge(input logic w);
    ws_arr[n_ent] = w;
    n_ent++;
  endtask

  task automatic sck_bit(input logic w, input logic d, output int rc);
    ws = w;
    sd = d;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    rc = cyc;
    repeat (4) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  task automatic play(input int lo, input int hi);
    int rc;
    for (int i = lo; i <= hi; i++) begin
      sck_bit(ws_arr[i], sd_arr[i], rc);
      rise_arr[i] = rc;
    end
  endtask

  // Disabled edge with ws=1 so the next enabled ws=0 edge is a WS change.
  task automatic prefix();
    int rc;
    en = 1'b0;
    sck_bit(1'b1, 1'b0, rc);
    en = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  len;
    int          slots;
    int          nbits;
    logic [31:0] wl;
    logic [31:0] wr;
    logic        fill;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tbl [0:4];

  initial begin
    int b_acc, b_ovf, b_err;

    tbl[0] = '{2'd1, 16, 16, 32'h0000A5C3, 32'h00001234, 1'b0, 32'h0000A5C3, 32'h00001234};
    tbl[1] = '{2'd1, 32, 16, 32'h0000BEEF, 32'h00007E81, 1'b1, 32'h0000BEEF, 32'h00007E81};
    tbl[2] = '{2'd3, 32, 32, 32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDEADBEEF, 32'h01234567};
    tbl[3] = '{2'd0, 16,  8, 32'hFFFFFF3C, 32'hFFFFFFC3, 1'b1, 32'h0000003C, 32'h000000C3};
    tbl[4] = '{2'd2, 32, 24, 32'hEEABCDEF, 32'h11654321, 1'b1, 32'h00ABCDEF, 32'h00654321};

    rst = 1'b1; en = 1'b0; len = 2'd1;
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    rx_bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset valid", {31'd0, rx_bus.valid}, 32'd0);
    check("reset data",  rx_bus.data, 32'd0);
    check("reset chn",   {31'd0, rx_bus.chn}, 32'd0);
    check("reset busy",  {31'd0, busy}, 32'd0);
    check("reset ovf",   {31'd0, ovf}, 32'd0);
    check("reset err",   {31'd0, err}, 32'd0);

    // Stereo frames from the vector table.
    for (int k = 0; k < 5; k++) begin
      rx_bus.ready = 1'b1;
      len = tbl[k].len;
      prefix();
      b_acc = acc_n; b_ovf = ovf_n; b_err = err_n;
      stream_clear();
      add_half(1'b0, tbl[k].slots, tbl[k].wl, tbl[k].nbits, tbl[k].fill);
      add_half(1'b1, tbl[k].slots, tbl[k].wr, tbl[k].nbits, tbl[k].fill);
      add_edge(1'b0);
      play(0, n_ent - 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      check($sformatf("v%0d words", k), acc_n - b_acc, 2);
      check($sformatf("v%0d left data", k), acc_data[b_acc], tbl[k].exp_l);
      check($sformatf("v%0d left chn", k), {31'd0, acc_chn[b_acc]}, 32'd0);
      check($sformatf("v%0d left latency", k),
            acc_cyc[b_acc] - rise_arr[tbl[k].nbits], 3);
      check($sformatf("v%0d right data", k), acc_data[b_acc + 1], tbl[k].exp_r);
      check($sformatf("v%0d right chn", k), {31'd0, acc_chn[b_acc + 1]}, 32'd1);
      check($sformatf("v%0d right latency", k),
            acc_cyc[b_acc + 1] - rise_arr[tbl[k].slots + tbl[k].nbits], 3);
      check($sformatf("v%0d err", k), err_n - b_err, 0);
      check($sformatf("v%0d ovf", k), ovf_n - b_ovf, 0);
    end

    // Overflow: consumer stalled for three 32-bit words.
    rx_bus.ready = 1'b0;
    len = 2'd3;
    prefix();
    b_acc = acc_n; b_ovf = ovf_n; b_err = err_n;
    stream_clear();
    add_half(1'b0, 32, 32'hDEADBEEF, 32, 1'b0);
    add_half(1'b1, 32, 32'h01234567, 32, 1'b0);
    add_half(1'b0, 32, 32'hDEADBEEF, 32, 1'b0);
    add_half(1'b1, 32, 32'h01234567, 32, 1'b0);
    add_edge(1'b0);
    play(0, 96);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ovf count",      ovf_n - b_ovf, 2);
    check("ovf held valid", {31'd0, rx_bus.valid}, 32'd1);
    check("ovf held data",  rx_bus.data, 32'hDEADBEEF);
    check("ovf held chn",   {31'd0, rx_bus.chn}, 32'd0);
    check("ovf no accept",  acc_n - b_acc, 0);
    rx_bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovf accept n",    acc_n - b_acc, 1);
    check("ovf accept data", acc_data[b_acc], 32'hDEADBEEF);
    check("ovf valid drop",  {31'd0, rx_bus.valid}, 32'd0);
    play(97, n_ent - 1);
    repeat (2) @(negedge clk);
    check("ovf next n",    acc_n - b_acc, 2);
    check("ovf next data", acc_data[b_acc + 1], 32'h01234567);
    check("ovf next chn",  {31'd0, acc_chn[b_acc + 1]}, 32'd1);
    check("ovf final cnt", ovf_n - b_ovf, 2);
    check("ovf err",       err_n - b_err, 0);
    en = 1'b0;

    // Short word: WS toggles after 20 of 24 bits.
    len = 2'd2;
    prefix();
    b_acc = acc_n; b_ovf = ovf_n; b_err = err_n;
    stream_clear();
    add_half(1'b0, 21, 32'h000F0F0F, 20, 1'b0);
    add_half(1'b1, 32, 32'h00ABCDEF, 24, 1'b0);
    add_edge(1'b0);
    play(0, n_ent - 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    check("short err",   err_n - b_err, 1);
    check("short words", acc_n - b_acc, 1);
    check("short data",  acc_data[b_acc], 32'h00ABCDEF);
    check("short chn",   {31'd0, acc_chn[b_acc]}, 32'd1);
    check("short ovf",   ovf_n - b_ovf, 0);

    // Enable dropped mid-word, raised again mid-frame.
    len = 2'd1;
    prefix();
    b_acc = acc_n; b_ovf = ovf_n; b_err = err_n;
    stream_clear();
    add_half(1'b0, 16, 32'h0000C001, 16, 1'b0);
    add_half(1'b1, 16, 32'h00002002, 16, 1'b0);
    add_half(1'b0, 16, 32'h00003AC3, 16, 1'b0);
    add_half(1'b1, 16, 32'h00004BD4, 16, 1'b0);
    add_edge(1'b0);
    play(0, 10);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en off busy", {31'd0, busy}, 32'd0);
    play(11, 20);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("en on idle busy", {31'd0, busy}, 32'd0);
    play(21, n_ent - 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    check("en words",  acc_n - b_acc, 2);
    check("en data l", acc_data[b_acc], 32'h00003AC3);
    check("en chn l",  {31'd0, acc_chn[b_acc]}, 32'd0);
    check("en data r", acc_data[b_acc + 1], 32'h00004BD4);
    check("en err",    err_n - b_err, 0);
    check("en ovf",    ovf_n - b_ovf, 0);

    // Reset mid-word with a word pending.
    rx_bus.ready = 1'b0;
    len = 2'd1;
    prefix();
    b_acc = acc_n;
    stream_clear();
    add_half(1'b0, 16, 32'h0000CAFE, 16, 1'b0);
    add_half(1'b1, 16, 32'h0000F00D, 16, 1'b0);
    add_edge(1'b0);
    play(0, 20);
    @(negedge clk);
    check("pre-rst valid", {31'd0, rx_bus.valid}, 32'd1);
    check("pre-rst data",  rx_bus.data, 32'h0000CAFE);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst valid", {31'd0, rx_bus.valid}, 32'd0);
    check("rst data",  rx_bus.data, 32'd0);
    check("rst chn",   {31'd0, rx_bus.chn}, 32'd0);
    check("rst busy",  {31'd0, busy}, 32'd0);
    check("rst ovf",   {31'd0, ovf}, 32'd0);
    check("rst err",   {31'd0, err}, 32'd0);
    rx_bus.ready = 1'b1;
    prefix();
    b_acc = acc_n; b_ovf = ovf_n; b_err = err_n;
    stream_clear();
    add_half(1'b0, 16, 32'h00005A5A, 16, 1'b0);
    add_half(1'b1, 16, 32'h0000A5A5, 16, 1'b0);
    add_edge(1'b0);
    play(0, n_ent - 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    check("post-rst words",  acc_n - b_acc, 2);
    check("post-rst data l", acc_data[b_acc], 32'h00005A5A);
    check("post-rst data r", acc_data[b_acc + 1], 32'h0000A5A5);
    check("post-rst chn r",  {31'd0, acc_chn[b_acc + 1]}, 32'd1);
    check("post-rst err",    err_n - b_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Slave-mode I2S receiver: samples externally driven SCK/WS/SD, deserializes one channel word per WS half-period and presents it on a valid/ready stream to the register/FIFO layer.
- Counterpart to the on-chip clock generator: consumes an I2S bit clock instead of producing one.
- Lives beside the transmitter path in the i2s subsystem.
- All logic runs in the system clock domain; the external lines are oversampled.

Parameters:
- DATA_WIDTH, 32 (`I2S_DATA_WIDTH`): output word width; also the maximum channel length.
- SYNC_STAGES, 2: synchronizer flops on sck_i/ws_i/sd_i.

Ports:
- clk_i  in  1  system clock; sole clock.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  receiver enable.
- len_i  in  2  channel length code: 0=8, 1=16, 2=24, 3=32 bits.
- sck_i  in  1  external I2S bit clock (async).
- ws_i  in  1  external word select, 0=left, 1=right (async).
- sd_i  in  1  external serial data, MSB first (async).
- data_o  out  DATA_WIDTH  received word, right-justified, zero-extended.
- chn_o  out  1  channel of data_o (0=left, 1=right).
- valid_o  out  1  data_o/chn_o valid.
- ready_i  in  1  consumer accepts when valid_o && ready_i.
- ovf_o  out  1  1-cycle pulse: completed word dropped because the output register was full.
- err_o  out  1  1-cycle pulse: WS toggled before len bits were collected.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): data_o=0, chn_o=0, valid_o=0, ovf_o=0, err_o=0, busy_o=0, state=IDLE, bit counter=0, shift register=0, synchronizers=0.
- Synchronization: sck/ws/sd each pass through SYNC_STAGES flops. An sck rising edge is detected when the synced sck is 1 and its previous value was 0. That detection cycle is the "bit event". ws and sd are taken from the same synced stage.
- Timing requirement: sck high and low phases are each ≥ 3 clk_i cycles.
- Bit-event processing, in this order within one cycle:
  1. If state=SHIFT: shift sd into the shift register LSB and increment cnt. If cnt reaches len, the word completes and state=DONE.
  2. WS change (ws != ws_q, where ws_q is ws latched at the previous bit event):
     - If state=SHIFT and the word did not complete in step 1: err_o pulses and the partial word is discarded.
     - In all states: state=SHIFT, cnt=0, shift register cleared, pending chn=ws.
  3. ws_q updates on every bit event.
- States and transitions:
  - IDLE → SHIFT only on a WS change.
  - DONE ignores sd (extra slot bits) until the next WS change.
  - A WS change reaches SHIFT from any state.
- Word completion:
  - Next cycle: data_o = shift register (zero-extended), chn_o = pending chn, valid_o=1.
  - Latency: 1 clk_i after the bit event of the LSB.
- Handshake:
  - valid_o holds, and data_o/chn_o stay stable, until valid_o && ready_i. valid_o falls the cycle after acceptance.
  - A word completing while valid_o=1 and ready_i=0: new word dropped, old word kept, ovf_o pulses.
  - Completion in the same cycle as acceptance: new word loaded, valid_o stays 1, no ovf.
- en_i=0: state forced to IDLE, cnt cleared, no err/ovf generated. A pending valid_o word remains and can still be accepted.
- Re-enable: first word starts at the next WS change. ws_q is tracked even while disabled, so a stale toggle is not misdetected.
- len_i is sampled at each WS change (start of word). Changes mid-word take effect on the next word.
- rst_i mid-word: everything returns to reset values in the next cycle; the partial word is lost without err_o.

Decomposition:
- Package i2s_define (shared):
  - `I2S_DATA_WIDTH`
  - len codes I2S_LEN_8/16/24/32
  - typedef enum rx_state_e {IDLE, SHIFT, DONE}
  - function mapping len code → bit count
- Sub-module i2s_edge_sync (parameter SYNC_STAGES): synchronizes sck/ws/sd and outputs sck_rise, ws_s, sd_s. Reusable by the future slave-mode transmitter (it needs the falling edge too, so also export sck_fall).

Test Plan:
- 16-bit stereo, 16 SCK per half, L=0xA5C3 then R=0x1234, ready_i=1 → two words: {chn 0, 0x0000A5C3}, {chn 1, 0x00001234}. Each valid_o 1 cycle after its LSB bit event. No err/ovf.
- len=1 with 32 SCK per half, L=0xBEEF followed by 16 trailing 1-bits → data_o=0x0000BEEF; trailing bits ignored (DONE); no err.
- len=3, 32-bit words 0xDEADBEEF/0x01234567 back-to-back, ready_i=0 for 3 words → first word held on data_o, ovf_o pulses exactly twice. After ready_i=1, 0xDEADBEEF is accepted and the next word arrives normally.
- len=2 (24 bits), WS toggles after 20 bits → err_o one pulse, no valid_o for that word. The following full 24-bit word 0x00ABCDEF is received correctly.
- en_i dropped after 10 bits of a 16-bit word, raised again mid-frame → no valid/err. Reception resumes with the first complete word after the next WS change.
- rst_i asserted for 1 cycle mid-word while valid_o=1 → next cycle all outputs 0, busy_o=0. The next full frame is received correctly.
